// File: rtl/rotator8_dual_if.sv
// Request/result bundle for rotator8_dual: operand, amount and direction in;
// rotated result, valid and sticky self-check flag out.
interface rotator8_dual_if;
    logic       in_valid;
    logic [7:0] a;
    logic [2:0] amt;
    logic       choice;
    logic [7:0] y;
    logic       out_valid;
    logic       mismatch;

    modport master (
        output in_valid, a, amt, choice,
        input  y, out_valid, mismatch
    );

    modport slave (
        input  in_valid, a, amt, choice,
        output y, out_valid, mismatch
    );
endinterface

// File: rtl/rotator8_dual.sv
// 8-bit bidirectional barrel rotator built twice: a log-stage network drives y,
// a case-per-amount network cross-checks it and sets a sticky mismatch flag.
module rotator8_dual #(
    parameter bit OUT_REG = 1'b1
) (
    input logic            clk,
    input logic            reset,
    rotator8_dual_if.slave bus
);

    logic [7:0] s0, s1, stage_y, case_y;
    logic [7:0] y_q;
    logic       out_valid_q, mismatch_q;

    // Log network: rotate by 1, 2, 4; choice=1 rotates left, 0 rotates right.
    always_comb begin
        s0 = bus.a;
        if (bus.amt[0]) s0 = bus.choice ? {bus.a[6:0], bus.a[7]} : {bus.a[0], bus.a[7:1]};
        s1 = s0;
        if (bus.amt[1]) s1 = bus.choice ? {s0[5:0], s0[7:6]} : {s0[1:0], s0[7:2]};
        stage_y = s1;
        // Rotate by 4 is the same in both directions.
        if (bus.amt[2]) stage_y = {s1[3:0], s1[7:4]};
    end

    always_comb begin
        case_y = bus.a;
        case ({bus.choice, bus.amt})
            4'b0000: case_y = bus.a;
            4'b0001: case_y = {bus.a[0],   bus.a[7:1]};
            4'b0010: case_y = {bus.a[1:0], bus.a[7:2]};
            4'b0011: case_y = {bus.a[2:0], bus.a[7:3]};
            4'b0100: case_y = {bus.a[3:0], bus.a[7:4]};
            4'b0101: case_y = {bus.a[4:0], bus.a[7:5]};
            4'b0110: case_y = {bus.a[5:0], bus.a[7:6]};
            4'b0111: case_y = {bus.a[6:0], bus.a[7]};
            4'b1000: case_y = bus.a;
            4'b1001: case_y = {bus.a[6:0], bus.a[7]};
            4'b1010: case_y = {bus.a[5:0], bus.a[7:6]};
            4'b1011: case_y = {bus.a[4:0], bus.a[7:5]};
            4'b1100: case_y = {bus.a[3:0], bus.a[7:4]};
            4'b1101: case_y = {bus.a[2:0], bus.a[7:3]};
            4'b1110: case_y = {bus.a[1:0], bus.a[7:2]};
            4'b1111: case_y = {bus.a[0],   bus.a[7:1]};
            default: case_y = bus.a;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            y_q         <= 8'h00;
            out_valid_q <= 1'b0;
            mismatch_q  <= 1'b0;
        end else begin
            out_valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                y_q <= stage_y;
                if (case_y != stage_y) mismatch_q <= 1'b1;
            end
        end
    end

    // Unregistered mode still uses y_q so y holds while in_valid is low.
    always_comb begin
        if (OUT_REG) begin
            bus.y         = y_q;
            bus.out_valid = out_valid_q;
        end else begin
            bus.y         = bus.in_valid ? stage_y : y_q;
            bus.out_valid = bus.in_valid;
        end
        bus.mismatch = mismatch_q;
    end

endmodule

// File: tb/tb_rotator8_dual.sv
// Directed-vector and exhaustive bench for rotator8_dual (OUT_REG=1).
module tb_rotator8_dual;

    logic clk = 1'b0;
    logic reset;
    int   passed = 0;
    int   total  = 0;

    always #5 clk = ~clk;

    rotator8_dual_if bus_if ();

    rotator8_dual #(.OUT_REG(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    typedef struct {
        logic [7:0] a;
        logic [2:0] amt;
        logic       choice;
        logic [7:0] exp_y;
    } vec_t;

    vec_t vecs[17];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Bit-level reference: right gives y[i]=a[(i+n)%8], left gives y[i]=a[(i-n)%8].
    function automatic logic [7:0] model(input logic [7:0] a, input int n, input logic left);
        logic [7:0] r;
        for (int i = 0; i < 8; i++)
            r[i] = left ? a[(i - n + 8) % 8] : a[(i + n) % 8];
        return r;
    endfunction

    task automatic drive(input logic [7:0] a, input logic [2:0] amt, input logic choice);
        bus_if.in_valid = 1'b1;
        bus_if.a        = a;
        bus_if.amt      = amt;
        bus_if.choice   = choice;
        @(posedge clk);
        #1;
    endtask

    task automatic set_vec(input int i, input logic [7:0] a, input logic [2:0] amt,
                           input logic choice, input logic [7:0] exp_y);
        vecs[i].a      = a;
        vecs[i].amt    = amt;
        vecs[i].choice = choice;
        vecs[i].exp_y  = exp_y;
    endtask

    initial begin
        set_vec(0,  8'b11010111, 3'd1, 1'b0, 8'b11101011);
        set_vec(1,  8'b11010111, 3'd2, 1'b0, 8'b11110101);
        set_vec(2,  8'b11010111, 3'd3, 1'b0, 8'b11111010);
        set_vec(3,  8'b11010111, 3'd7, 1'b0, 8'b10101111);
        set_vec(4,  8'b11110011, 3'd1, 1'b1, 8'b11100111);
        set_vec(5,  8'b11110011, 3'd2, 1'b1, 8'b11001111);
        set_vec(6,  8'b11110011, 3'd4, 1'b1, 8'b00111111);
        set_vec(7,  8'b11110011, 3'd7, 1'b1, 8'b11111001);
        set_vec(8,  8'h01, 3'd1, 1'b1, 8'h02);
        set_vec(9,  8'h01, 3'd2, 1'b1, 8'h04);
        set_vec(10, 8'h01, 3'd3, 1'b1, 8'h08);
        set_vec(11, 8'h01, 3'd4, 1'b0, 8'h10);
        set_vec(12, 8'h01, 3'd5, 1'b0, 8'h08);
        set_vec(13, 8'h01, 3'd6, 1'b0, 8'h04);
        set_vec(14, 8'h01, 3'd7, 1'b0, 8'h02);
        set_vec(15, 8'hA5, 3'd0, 1'b0, 8'hA5);
        set_vec(16, 8'hA5, 3'd0, 1'b1, 8'hA5);

        reset           = 1'b1;
        bus_if.in_valid = 1'b0;
        bus_if.a        = 8'h00;
        bus_if.amt      = 3'd0;
        bus_if.choice   = 1'b0;
        #1;
        check("reset_y", bus_if.y, 8'h00);
        check("reset_out_valid", {7'd0, bus_if.out_valid}, 8'h00);
        check("reset_mismatch", {7'd0, bus_if.mismatch}, 8'h00);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            drive(vecs[i].a, vecs[i].amt, vecs[i].choice);
            check($sformatf("vec%0d_y", i), bus_if.y, vecs[i].exp_y);
            check($sformatf("vec%0d_out_valid", i), {7'd0, bus_if.out_valid}, 8'h01);
            check($sformatf("vec%0d_mismatch", i), {7'd0, bus_if.mismatch}, 8'h00);
        end

        // Hold: inputs go unknown while idle; y must keep A5.
        bus_if.in_valid = 1'b0;
        bus_if.amt      = 3'bxxx;
        bus_if.choice   = 1'bx;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("hold%0d_y", c), bus_if.y, 8'hA5);
            check($sformatf("hold%0d_out_valid", c), {7'd0, bus_if.out_valid}, 8'h00);
            check($sformatf("hold%0d_mismatch", c), {7'd0, bus_if.mismatch}, 8'h00);
        end

        for (int d = 0; d < 2; d++)
            for (int n = 0; n < 8; n++)
                for (int v = 0; v < 256; v++) begin
                    drive(8'(v), 3'(n), d[0]);
                    check($sformatf("exh_y a=%0h n=%0d d=%0d", v, n, d), bus_if.y,
                          model(8'(v), n, d[0]));
                    check("exh_out_valid", {7'd0, bus_if.out_valid}, 8'h01);
                end
        check("exh_mismatch", {7'd0, bus_if.mismatch}, 8'h00);

        // Reset between edges while an operation is being presented.
        bus_if.in_valid = 1'b1;
        bus_if.a        = 8'h3C;
        bus_if.amt      = 3'd2;
        bus_if.choice   = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        check("midreset_y", bus_if.y, 8'h00);
        check("midreset_out_valid", {7'd0, bus_if.out_valid}, 8'h00);
        check("midreset_mismatch", {7'd0, bus_if.mismatch}, 8'h00);
        @(posedge clk);
        #1;
        check("inreset_y", bus_if.y, 8'h00);
        check("inreset_out_valid", {7'd0, bus_if.out_valid}, 8'h00);
        bus_if.in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("postreset_idle_out_valid", {7'd0, bus_if.out_valid}, 8'h00);
        check("postreset_idle_y", bus_if.y, 8'h00);
        drive(8'h81, 3'd1, 1'b0);
        check("postreset_y", bus_if.y, 8'hC0);
        check("postreset_out_valid", {7'd0, bus_if.out_valid}, 8'h01);
        check("postreset_mismatch", {7'd0, bus_if.mismatch}, 8'h00);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
